// File: rtl/icache_axi_refill.sv
// icache_axi_refill: AXI4 read-burst master that fetches one 8-word
// instruction-cache line per request and hands it back in parallel with a
// single-cycle grant. The line buffer is held until the next burst's first beat.
module icache_axi_refill #(
    parameter logic [3:0]  ARID       = 4'd0,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // icache refill port
    input  logic                         rd_req,
    input  logic [31:0]                  rd_addr,
    output logic                         rd_gnt,
    output logic [LINE_WORDS-1:0][31:0]  rd_data,
    output logic                         rd_err,
    // AXI4 read address channel
    output logic [3:0]                   arid,
    output logic [31:0]                  araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,
    // AXI4 read data channel
    input  logic [3:0]                   rid,
    input  logic [31:0]                  rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready
);

    localparam int unsigned       BEAT_W     = $clog2(LINE_WORDS);
    localparam int unsigned       OFFSET_W   = 5;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [2:0]        SIZE_WORD  = 3'b010;
    localparam logic [1:0]        BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic                          err_q, err_d;
    logic [31:0]                   araddr_q, araddr_d;
    logic [LINE_WORDS-1:0][31:0]   rd_data_q, rd_data_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          rd_gnt_q, rd_gnt_d;
    logic                          rd_err_q, rd_err_d;

    logic                          beat_fire;
    logic                          beat_bad;

    // Line offset bits of the miss address are irrelevant to a full-line burst.
    logic [OFFSET_W-1:0]           unused_addr_bits;
    assign unused_addr_bits = rd_addr[OFFSET_W-1:0];

    // Fixed burst shape: one full line of word-sized INCR beats.
    assign arid    = ARID;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;

    assign araddr  = araddr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign rd_gnt  = rd_gnt_q;
    assign rd_err  = rd_err_q;
    assign rd_data = rd_data_q;

    // Next-state, line-buffer capture and registered-output decode.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        err_d     = err_q;
        araddr_d  = araddr_q;
        rd_data_d = rd_data_q;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        rd_gnt_d  = 1'b0;
        rd_err_d  = 1'b0;

        beat_fire = rvalid & rready_q;
        // Any bad response, foreign ID, or rlast not exactly on the final beat.
        beat_bad  = (rresp != 2'b00) | (rid != ARID) | (rlast != (beat_q == LAST_BEAT));

        unique case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    araddr_d  = {rd_addr[31:OFFSET_W], OFFSET_W'(0)};
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arvalid_q && arready) begin
                    beat_d   = '0;
                    err_d    = 1'b0;
                    rready_d = 1'b1;
                    state_d  = S_DATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            S_DATA: begin
                rready_d = 1'b1;
                if (beat_fire) begin
                    rd_data_d[beat_q] = rdata;
                    err_d             = err_q | beat_bad;
                    // The beat count, not rlast, decides when the line is complete.
                    if (beat_q == LAST_BEAT) begin
                        rready_d = 1'b0;
                        rd_gnt_d = 1'b1;
                        rd_err_d = err_q | beat_bad;
                        state_d  = S_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            err_q     <= 1'b0;
            araddr_q  <= '0;
            rd_data_q <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rd_gnt_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            araddr_q  <= araddr_d;
            rd_data_q <= rd_data_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rd_gnt_q  <= rd_gnt_d;
            rd_err_q  <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: directed bursts driven by a simple AXI slave
// task, a transaction-level reference model checked every cycle, and literal
// expectations for latency, line contents and error reporting.
module tb_icache_axi_refill;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b1;
    logic               rd_req  = 1'b0;
    logic [31:0]        rd_addr = '0;
    logic               rd_gnt;
    logic [7:0][31:0]   rd_data;
    logic               rd_err;
    logic [3:0]         arid;
    logic [31:0]        araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready = 1'b0;
    logic [3:0]         rid     = '0;
    logic [31:0]        rdata   = '0;
    logic [1:0]         rresp   = '0;
    logic               rlast   = 1'b0;
    logic               rvalid  = 1'b0;
    logic               rready;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    icache_axi_refill dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_gnt  (rd_gnt),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    // Free-running clock and cycle counter.
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase 0 waiting, 1 address offered, 2 collecting beats,
    // 3 line granted. Tracks the expected line, address and sticky error.
    int               m_phase = 0;
    int               m_beats = 0;
    logic             m_err   = 1'b0;
    logic [31:0]      m_araddr = '0;
    logic [7:0][31:0] m_line  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_beats = 0; m_err = 1'b0; m_araddr = '0; m_line = '0;
        end else begin
            case (m_phase)
                0: if (rd_req) begin
                    m_araddr = rd_addr & 32'hFFFF_FFE0;
                    m_phase  = 1;
                end
                1: if (arready) begin
                    m_phase = 2; m_beats = 0; m_err = 1'b0;
                end
                2: if (rvalid) begin
                    m_line[m_beats[2:0]] = rdata;
                    if (rresp != 2'b00 || rid != 4'd0 || rlast != (m_beats == 7)) m_err = 1'b1;
                    m_beats++;
                    if (m_beats == 8) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("arvalid", arvalid, m_phase == 1);
        chk("rready",  rready,  m_phase == 2);
        chk("rd_gnt",  rd_gnt,  m_phase == 3);
        chk("rd_err",  rd_err,  (m_phase == 3) && m_err);
        chk("araddr",  araddr,  m_araddr);
        chk("rd_data", rd_data, m_line);
        chk("ar_const", {arid, arlen, arsize, arburst}, {4'd0, 8'd7, 3'd2, 2'd1});
    end

    // One refill from the cache side plus a scripted AXI slave.
    task automatic run_burst(input string tag, input logic [31:0] addr, input logic [31:0] exp_araddr,
                             input int ar_low, input bit gap, input bit junk, input bit drop_req,
                             input int err_beat, input int rid_beat, input int rlast_beat,
                             input int abort_after, input logic [31:0] base, input logic [31:0] prev0,
                             input logic exp_err, input int exp_gnt);
        int start, beat, tmo;
        bit tog, seen_ar, done;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = addr; arready = (ar_low == 0); rvalid = 1'b0;
        start = cyc; beat = 0; tog = 1'b1; seen_ar = 1'b0; done = 1'b0; tmo = 0;
        while (!done && tmo < 100) begin
            @(posedge clk); #1;
            tmo++;
            if (abort_after > 0 && beat == abort_after) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, "_rst_arvalid"}, arvalid, 1'b0);
                chk({tag, "_rst_rready"},  rready,  1'b0);
                chk({tag, "_rst_gnt"},     rd_gnt,  1'b0);
                chk({tag, "_rst_data"},    rd_data, 256'd0);
                rd_req = 1'b0; rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
                return;
            end
            if (rd_gnt) begin
                chk({tag, "_gnt_cycle"}, cyc - start, exp_gnt);
                chk({tag, "_err"}, rd_err, exp_err);
                for (int i = 0; i < 8; i++) chk({tag, "_word"}, rd_data[i], base + i);
                rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rresp = 2'b00;
                done = 1'b1;
            end else begin
                if (arvalid && !seen_ar) begin
                    seen_ar = 1'b1;
                    chk({tag, "_ar_latency"}, cyc - start, 1);
                    chk({tag, "_araddr"}, araddr, exp_araddr);
                    chk({tag, "_old_word0"}, rd_data[0], prev0);
                    if (drop_req) rd_req = 1'b0;
                end
                if (arvalid) begin
                    if (ar_low > 0) begin arready = 1'b0; ar_low--; end
                    else arready = 1'b1;
                end
                if (rready && beat < 8) begin
                    rvalid = gap ? tog : 1'b1;
                    tog = !tog;
                    if (rvalid) begin
                        rdata = base + beat;
                        rresp = (beat == err_beat) ? 2'b10 : 2'b00;
                        rid   = (beat == rid_beat) ? 4'd5 : 4'd0;
                        rlast = (beat == rlast_beat);
                        beat++;
                    end else begin
                        rdata = 32'hBAD0_0000; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
                    end
                end else begin
                    rvalid = junk; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rid = 4'd0; rlast = junk;
                end
            end
        end
        if (!done) chk({tag, "_gnt_timeout"}, 1'b0, 1'b1);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    initial begin
        int g;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_arvalid", arvalid, 1'b0);
        chk("reset_rready",  rready,  1'b0);
        chk("reset_gnt",     rd_gnt,  1'b0);
        chk("reset_araddr",  araddr,  32'd0);
        chk("reset_data",    rd_data, 256'd0);

        // Basic refill, arready and rvalid always high.
        run_burst("basic", 32'hBFC0_0014, 32'hBFC0_0000, 0, 0, 0, 0, -1, -1, 7, 0, 32'h1000, 32'h0, 1'b0, 10);
        chk("basic_arlen", arlen, 8'd7);
        chk("basic_arsize", arsize, 3'd2);
        chk("basic_arburst", arburst, 2'd1);
        // Address stall of 3 cycles, alternating rvalid, junk beats outside DATA, early rd_req drop.
        run_burst("bp", 32'h0000_1234, 32'h0000_1220, 3, 1, 1, 1, -1, -1, 7, 0, 32'h2000, 32'h1000, 1'b0, 20);
        // Error response on beat 3, then a clean refill clears the error.
        run_burst("slverr", 32'h0000_0100, 32'h0000_0100, 0, 0, 0, 0, 3, -1, 7, 0, 32'h3000, 32'h2000, 1'b1, 10);
        run_burst("clean", 32'h0000_021C, 32'h0000_0200, 0, 0, 0, 0, -1, -1, 7, 0, 32'h4000, 32'h3000, 1'b0, 10);
        // rlast on beat 5 only: no early grant, error at grant.
        run_burst("rlast5", 32'h0000_0300, 32'h0000_0300, 0, 0, 0, 0, -1, -1, 5, 0, 32'h5000, 32'h4000, 1'b1, 10);
        // rlast never asserted, and a foreign rid on beat 6.
        run_burst("nolast", 32'h0000_0340, 32'h0000_0340, 0, 0, 0, 0, -1, -1, -1, 0, 32'h6000, 32'h5000, 1'b1, 10);
        run_burst("badrid", 32'h0000_0380, 32'h0000_0380, 0, 0, 0, 0, -1, 6, 7, 0, 32'h7000, 32'h6000, 1'b1, 10);

        // Line held two cycles after grant, then back-to-back request.
        run_burst("hold_a", 32'h0000_0400, 32'h0000_0400, 0, 0, 0, 0, -1, -1, 7, 0, 32'hA000, 32'h7000, 1'b0, 10);
        for (int i = 0; i < 8; i++) chk("hold_c1", rd_data[i], 32'hA000 + i);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) chk("hold_c2", rd_data[i], 32'hA000 + i);
        run_burst("b2b", 32'h8000_0040, 32'h8000_0040, 0, 0, 0, 0, -1, -1, 7, 0, 32'hB000, 32'hA000, 1'b0, 10);

        // Asynchronous reset after beat 4; no grant may follow.
        run_burst("midrst", 32'h0000_0500, 32'h0000_0500, 0, 0, 0, 0, -1, -1, 7, 5, 32'hC000, 32'hB000, 1'b0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        g = 0;
        repeat (15) begin
            @(negedge clk);
            g += int'(rd_gnt) + int'(arvalid);
        end
        chk("midrst_quiet", g, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- AXI4 read-burst master that refills the instruction cache: one 8-word (32-byte) line per request.
- Sits directly downstream of the icache refill port. Consumes its level request and line address, and returns the whole line in parallel with a one-cycle grant.
- Line buffer is held stable after the grant so the cache can write all banks in the following cycle.

Parameters:
- ARID, 4'd0, AXI ID driven on arid; also the only rid value accepted.
- LINE_WORDS, 8, words per line; the burst is LINE_WORDS beats (arlen = LINE_WORDS-1). Only 8 is supported.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  refill request from icache (level)
- rd_addr  in  32  miss address; low 5 bits ignored
- rd_gnt  out  1  one-cycle pulse: rd_data holds the complete line
- rd_data  out  8x32  line buffer, word i = bytes 4i..4i+3 of the line
- rd_err  out  1  pulse with rd_gnt if any beat had an error or a protocol violation
- arid  out  4  = ARID
- araddr  out  32  {latched_addr[31:5], 5'b0}
- arlen  out  8  = 7
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01 (INCR)
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rid  in  4  read ID
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; beat counter = 0; error flag = 0.
  - Outputs: arvalid = 0, rready = 0, rd_gnt = 0, rd_err = 0, araddr = 0, rd_data all 0.
- Reset mid-burst: the transaction is abandoned. No grant is produced, and the interconnect is assumed reset alongside.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If rd_req = 1: latch rd_addr[31:5] and go to ADDR. arvalid rises on the next cycle.
  - rd_data keeps its previous contents.
- ADDR:
  - arvalid = 1; araddr, arlen, arsize and arburst held constant.
  - On arvalid & arready: go to DATA; beat counter = 0; error flag = 0.
- DATA:
  - rready = 1. Each rvalid & rready beat writes rdata into rd_data[beat] and increments the counter (3-bit, no wrap beyond 7).
  - Error flag is set (sticky) on any of:
    - rresp != 2'b00;
    - rid != ARID;
    - rlast = 1 on a beat other than 7;
    - rlast = 0 on beat 7.
  - Beat 7 accepted: go to DONE, regardless of rlast.
  - An early rlast does not end the burst; the block keeps waiting for the full 8 beats.
- DONE:
  - rd_gnt = 1 and rd_err = error flag for exactly one cycle; then go to IDLE.
  - rready = 0 and arvalid = 0.
- rd_data stability:
  - rd_data is stable from the DONE cycle until the first beat of the next burst.
  - It is never modified in IDLE or ADDR, so the cache's write cycle after rd_gnt sees valid data.
- Request level handling:
  - rd_req is sampled only in IDLE. Deassertion during ADDR or DATA does not cancel the burst, since AXI forbids dropping arvalid.
  - The cache deasserts rd_req in the cycle after rd_gnt. Therefore IDLE must not see a stale request, which holds because DONE lasts one cycle and IDLE samples afterward.
- Latency: rd_req high in IDLE at cycle 0 gives arvalid at cycle 1. With arready and rvalid always high, beats land in cycles 2..9 and rd_gnt is in cycle 10.
- Only one outstanding transaction. Backpressure by rvalid gaps only stretches DATA.
- Beats arriving with rvalid outside DATA are not accepted (rready = 0).

Test Plan:
- Basic refill:
  - Stimulus: rd_addr = 0xBFC0_0014; arready tied 1; rdata = 0x1000+i on beat i; rlast on beat 7; rresp = 0.
  - Required: araddr = 0xBFC0_0000, arlen = 7, arsize = 2, arburst = 1; rd_gnt at cycle 10; rd_data[i] = 0x1000+i; rd_err = 0.
- Backpressure:
  - Stimulus: arready low for 3 cycles; rvalid toggling 1,0,1,0…
  - Required: arvalid and araddr stable until handshake; 8 beats captured in order; single rd_gnt pulse; data correct.
- Error response:
  - Stimulus: beat 3 has rresp = 2'b10.
  - Required: all 8 beats stored; rd_gnt with rd_err = 1.
  - Follow-up: next clean refill gives rd_err = 0.
- rlast violation:
  - Stimulus: rlast asserted on beat 5.
  - Required: no early grant; waits for beat 7; rd_err = 1 at rd_gnt.
- Data hold and back-to-back:
  - Stimulus: after rd_gnt, check rd_data unchanged for 2 cycles. Then raise rd_req with rd_addr = 0x8000_0040.
  - Required: arvalid one cycle later with araddr = 0x8000_0040; old rd_data kept until first new beat.
- Async reset mid-burst:
  - Stimulus: drop rst_n after beat 4, between clock edges.
  - Required: arvalid, rready, rd_gnt immediately 0 and rd_data = 0. After release with rd_req = 0 the block stays IDLE and no rd_gnt appears.
